sample_packetizer: RTL and testbench

- Upstream neighbour of the FTDI synchronous-FIFO writer, in the `ftdiclk` (60 MHz) domain.
- Captures one multi-channel ADC sample strobe at a time.
- Serializes the sample into a framed byte packet: sync, sequence number, big-endian channel words, optional checksum.
- Presents the packet as a valid/ready byte stream that the FTDI writer drains whenever `ftdi_txe_n` permits.

---
 rtl/sample_packetizer_pkg.sv | 21 ++
 rtl/sample_packetizer_if.sv | 22 ++
 rtl/sample_packetizer_sat_counter.sv | 23 ++
 rtl/sample_packetizer.sv | 151 +++++++++++++++
 tb/tb_sample_packetizer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sample_packetizer_pkg.sv
// Shared framing definitions for the sample packetizer and its FTDI writer.
// Checksum framing is selected by the TEACHEE_PKT_CHECKSUM_EN macro.
package teachee_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SYNC = 3'd1,
        SEQ  = 3'd2,
        DATA = 3'd3,
        CSUM = 3'd4
    } pkt_state_t;

    localparam int         SAMPLE_WIDTH = 16;
    localparam logic [7:0] PKT_SYNC     = 8'hA5;

    // Big-endian byte pick from one channel word: hi selects bits [15:8].
    function automatic logic [7:0] word_byte(input logic [SAMPLE_WIDTH-1:0] w, input logic hi);
        return hi ? w[15:8] : w[7:0];
    endfunction

endpackage

// File: rtl/sample_packetizer_if.sv
// Sample-strobe input and valid/ready byte stream between source, packetizer and FTDI writer.
// valid/ready: a byte moves on a cycle where out_valid && out_ready; out_data/out_valid hold while stalled.
interface sample_packetizer_if #(
    parameter int NUM_CHANNELS = 2
);
    logic [teachee_pkg::SAMPLE_WIDTH*NUM_CHANNELS-1:0] sample_data;
    logic                                              sample_valid;
    logic                                              sample_ready;
    logic [7:0]                                        out_data;
    logic                                              out_valid;
    logic                                              out_ready;

    modport slave (
        input  sample_data, sample_valid, out_ready,
        output sample_ready, out_data, out_valid
    );

    modport master (
        output sample_data, sample_valid, out_ready,
        input  sample_ready, out_data, out_valid
    );
endinterface

// File: rtl/sample_packetizer_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/sample_packetizer.sv
// Frames one multi-channel ADC sample into SYNC/seq/big-endian-data[/checksum] bytes.
// Define TEACHEE_PKT_CHECKSUM_EN to append the 8-bit modular checksum byte.
module sample_packetizer
    import teachee_pkg::*;
#(
    parameter int         NUM_CHANNELS = 2,
    parameter logic [7:0] SYNC_BYTE    = PKT_SYNC
) (
    input  logic                ftdiclk,
    input  logic                reset,
    sample_packetizer_if.slave  bus,
    output logic [15:0]         drop_count,
    output pkt_state_t          o_dbg_state
);
    localparam int         DW       = SAMPLE_WIDTH * NUM_CHANNELS;
    localparam logic [3:0] LAST_IDX = 4'(2 * NUM_CHANNELS - 1);

    pkt_state_t        r_state, w_state_nxt;
    logic [3:0]        r_idx, w_idx_nxt;
    logic [DW-1:0]     r_hold, w_hold_nxt;
    logic [7:0]        r_seq, w_seq_nxt;
    logic [7:0]        r_out_data, w_out_data_nxt;
    logic              r_out_valid;
    logic              w_fire, w_last, w_accept, w_drop;
    logic [15:0]       w_word;
    logic [7:0]        w_data_byte;

    assign w_fire = r_out_valid && bus.out_ready;

`ifdef TEACHEE_PKT_CHECKSUM_EN
    logic [7:0] r_csum, w_csum_nxt;
    assign w_last = w_fire && (r_state == CSUM);
`else
    assign w_last = w_fire && (r_state == DATA) && (r_idx == LAST_IDX);
`endif

    // A new sample may be taken while idle or as the final byte leaves.
    assign bus.sample_ready = (r_state == IDLE) || w_last;
    assign w_accept         = bus.sample_valid && bus.sample_ready;
    assign w_drop           = bus.sample_valid && !bus.sample_ready;
    assign w_hold_nxt       = w_accept ? bus.sample_data : r_hold;
    assign w_seq_nxt        = w_last ? (r_seq + 8'd1) : r_seq;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = SYNC;
            SYNC: if (w_fire) w_state_nxt = SEQ;
            SEQ: begin
                if (w_fire) begin
                    w_state_nxt = DATA;
                    w_idx_nxt   = '0;
                end
            end
            DATA: begin
                if (w_fire) begin
                    if (r_idx == LAST_IDX) begin
`ifdef TEACHEE_PKT_CHECKSUM_EN
                        w_state_nxt = CSUM;
`else
                        w_state_nxt = w_accept ? SYNC : IDLE;
`endif
                    end else begin
                        w_idx_nxt = r_idx + 4'd1;
                    end
                end
            end
            CSUM: begin
`ifdef TEACHEE_PKT_CHECKSUM_EN
                if (w_fire) w_state_nxt = w_accept ? SYNC : IDLE;
`else
                w_state_nxt = IDLE;
`endif
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Channel word for the byte about to be presented; idx[3:1] is the channel.
    always_comb begin
        w_word = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (w_idx_nxt[3:1] == 3'(k)) begin
                w_word = w_hold_nxt[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            end
        end
        w_data_byte = word_byte(w_word, !w_idx_nxt[0]);
    end

`ifdef TEACHEE_PKT_CHECKSUM_EN
    always_comb begin
        w_csum_nxt = r_csum;
        if ((w_state_nxt == SYNC) && (r_state != SYNC)) begin
            w_csum_nxt = '0;
        end else if (w_fire && ((r_state == SEQ) || (r_state == DATA))) begin
            w_csum_nxt = r_csum + r_out_data;
        end
    end

    always_ff @(posedge ftdiclk) begin
        if (reset) begin
            r_csum <= '0;
        end else begin
            r_csum <= w_csum_nxt;
        end
    end
`endif

    always_comb begin
        w_out_data_nxt = '0;
        case (w_state_nxt)
            SYNC: w_out_data_nxt = SYNC_BYTE;
            SEQ:  w_out_data_nxt = w_seq_nxt;
            DATA: w_out_data_nxt = w_data_byte;
`ifdef TEACHEE_PKT_CHECKSUM_EN
            CSUM: w_out_data_nxt = w_csum_nxt;
`endif
            default: w_out_data_nxt = '0;
        endcase
    end

    always_ff @(posedge ftdiclk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_hold      <= '0;
            r_seq       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_hold      <= w_hold_nxt;
            r_seq       <= w_seq_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= (w_state_nxt != IDLE);
        end
    end

    sat_counter #(.WIDTH(16)) u_drop_cnt (
        .clk     (ftdiclk),
        .rst     (reset),
        .i_inc   (w_drop),
        .o_count (drop_count)
    );

    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_sample_packetizer.sv
// Directed bench for sample_packetizer: table of packets plus hand-written corner sequences.
// Works with or without TEACHEE_PKT_CHECKSUM_EN defined.
module tb_sample_packetizer;
    import teachee_pkg::*;

    localparam int N = 2;
`ifdef TEACHEE_PKT_CHECKSUM_EN
    localparam int PKT_LEN = 7;
`else
    localparam int PKT_LEN = 6;
`endif

    logic        ftdiclk = 1'b0;
    logic        reset   = 1'b1;
    logic [15:0] drop_count;
    pkt_state_t  dbg_state;

    sample_packetizer_if #(.NUM_CHANNELS(N)) bus ();

    sample_packetizer #(.NUM_CHANNELS(N), .SYNC_BYTE(PKT_SYNC)) dut (
        .ftdiclk     (ftdiclk),
        .reset       (reset),
        .bus         (bus.slave),
        .drop_count  (drop_count),
        .o_dbg_state (dbg_state)
    );

    always #5 ftdiclk = ~ftdiclk;

    typedef struct {
        logic [31:0] sample;     // {ch1, ch0}
        logic [55:0] exp_bytes;  // packet bytes, first byte in the top octet
    } vec_t;

    vec_t        vecs[4];
    logic [7:0]  exp_q[$];
    int          n_vec  = 0;
    int          n_fail = 0;

    localparam logic [31:0] S0     = {16'hABCD, 16'h1234};
    localparam logic [55:0] P0_SEQ0 = 56'hA5_00_1234_ABCD_BE;
    localparam logic [55:0] P1_SEQ1 = 56'hA5_01_0000_0000_01;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_edge();
        @(posedge ftdiclk);
        #1;
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        bus.sample_valid = 1'b0;
        bus.sample_data  = '0;
        bus.out_ready    = 1'b0;
        wait_edge();
        wait_edge();
        reset = 1'b0;
    endtask

    task automatic load_exp(input logic [55:0] b);
        for (int i = 0; i < PKT_LEN; i++) exp_q.push_back(b[55-8*i -: 8]);
    endtask

    task automatic strobe(input logic [31:0] d, input logic exp_ready, input string name);
        bus.sample_data  = d;
        bus.sample_valid = 1'b1;
        @(negedge ftdiclk);
        chk(name, 32'(bus.sample_ready), 32'(exp_ready));
        wait_edge();
        bus.sample_valid = 1'b0;
    endtask

    // Pops one expected byte per handshake; stalled cycles must hold out_data.
    task automatic drain(input bit bp, input string name);
        int         cyc     = 0;
        bit         stalled = 1'b0;
        logic [7:0] held    = '0;
        while (exp_q.size() > 0 && cyc < 300) begin
            bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge ftdiclk);
            chk($sformatf("%s_valid", name), 32'(bus.out_valid), 32'd1);
            if (stalled) chk($sformatf("%s_hold", name), 32'(bus.out_data), 32'(held));
            if (bus.out_ready) begin
                chk($sformatf("%s_byte", name), 32'(bus.out_data), 32'(exp_q.pop_front()));
                stalled = 1'b0;
            end else begin
                held    = bus.out_data;
                stalled = 1'b1;
            end
            wait_edge();
            cyc++;
        end
        if (exp_q.size() > 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d bytes left expected 0", name, exp_q.size());
            exp_q.delete();
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic chk_idle(input string name);
        @(negedge ftdiclk);
        chk($sformatf("%s_valid0", name), 32'(bus.out_valid), 32'd0);
        chk($sformatf("%s_data0", name), 32'(bus.out_data), 32'd0);
        wait_edge();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{S0,                         P0_SEQ0};
        vecs[1] = '{32'h0000_0000,              P1_SEQ1};
        vecs[2] = '{{16'h0001, 16'hFFFF},       56'hA5_02_FFFF_0001_01};
        vecs[3] = '{{16'h5A5A, 16'h00FF},       56'hA5_03_00FF_5A5A_B6};

        // Reset state
        do_reset();
        @(negedge ftdiclk);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        chk("rst_ready", 32'(bus.sample_ready), 32'd1);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        wait_edge();

        // Table of packets, seq 0..3
        for (int i = 0; i < 4; i++) begin
            strobe(vecs[i].sample, 1'b1, "tbl_accept");
            load_exp(vecs[i].exp_bytes);
            drain(1'b0, "tbl");
            chk_idle("tbl");
        end

        // Backpressure
        do_reset();
        strobe(S0, 1'b1, "bp_accept");
        load_exp(P0_SEQ0);
        drain(1'b1, "bp");
        chk_idle("bp");

        // Drops while a packet is stalled
        do_reset();
        strobe(S0, 1'b1, "drop_accept");
        for (int i = 0; i < 3; i++) strobe(32'hDEAD_BEEF, 1'b0, "drop_ready");
        @(negedge ftdiclk);
        chk("drop_count3", 32'(drop_count), 32'd3);
        wait_edge();
        load_exp(P0_SEQ0);
        drain(1'b0, "drop_pkt");
        strobe(32'h0000_0000, 1'b1, "drop_next_accept");
        load_exp(P1_SEQ1);
        drain(1'b0, "drop_next");
        chk_idle("drop");

        // Back-to-back packets: 301 packets, seq wraps past 8'hFF
        do_reset();
        bus.out_ready = 1'b1;
        strobe(S0, 1'b1, "b2b_first");
        for (int p = 0; p <= 300; p++) begin
            for (int b = 0; b < PKT_LEN; b++) begin
                logic [7:0] eb;
                case (b)
                    0: eb = 8'hA5;
                    1: eb = 8'(p);
                    2: eb = 8'h12;
                    3: eb = 8'h34;
                    4: eb = 8'hAB;
                    5: eb = 8'hCD;
                    default: eb = 8'(p) + 8'hBE;
                endcase
                bus.sample_data  = S0;
                bus.sample_valid = (b == PKT_LEN - 1) && (p < 300);
                @(negedge ftdiclk);
                chk("b2b_valid", 32'(bus.out_valid), 32'd1);
                chk("b2b_byte", 32'(bus.out_data), 32'(eb));
                if (p == 300 && b == 1) chk("b2b_seq300", 32'(bus.out_data), 32'h2C);
                if (b == PKT_LEN - 1) chk("b2b_ready", 32'(bus.sample_ready), 32'd1);
                wait_edge();
            end
        end
        bus.sample_valid = 1'b0;
        bus.out_ready    = 1'b0;
        chk_idle("b2b");

        // Reset mid-packet (DATA index 1) after seq and drop_count have moved
        do_reset();
        strobe(S0, 1'b1, "mid_first");
        load_exp(P0_SEQ0);
        drain(1'b0, "mid_first");
        strobe(S0, 1'b1, "mid_second");
        bus.out_ready    = 1'b1;
        bus.sample_valid = 1'b1;
        wait_edge();
        bus.sample_valid = 1'b0;
        wait_edge();
        wait_edge();
        @(negedge ftdiclk);
        chk("mid_state", 32'(dbg_state), 32'(DATA));
        chk("mid_byte", 32'(bus.out_data), 32'h34);
        chk("mid_drop", 32'(drop_count), 32'd1);
        reset = 1'b1;
        wait_edge();
        reset         = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge ftdiclk);
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_drop", 32'(drop_count), 32'd0);
        chk("mid_rst_state", 32'(dbg_state), 32'(IDLE));
        chk("mid_rst_ready", 32'(bus.sample_ready), 32'd1);
        wait_edge();
        strobe(S0, 1'b1, "mid_after");
        load_exp(P0_SEQ0);
        drain(1'b0, "mid_after");
        chk_idle("mid");

        // drop_count saturation
        do_reset();
        force dut.u_drop_cnt.r_count = 16'hFFFE;
        wait_edge();
        release dut.u_drop_cnt.r_count;
        @(negedge ftdiclk);
        chk("sat_pre", 32'(drop_count), 32'hFFFE);
        wait_edge();
        strobe(S0, 1'b1, "sat_accept");
        for (int i = 0; i < 3; i++) begin
            strobe(32'h0, 1'b0, "sat_ready");
            @(negedge ftdiclk);
            chk("sat_count", 32'(drop_count), 32'hFFFF);
            wait_edge();
        end
        load_exp(P0_SEQ0);
        drain(1'b0, "sat_pkt");
        chk_idle("sat");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
